// File: rtl/vga_pixel_unpack_pkg.sv
// Shared VGA types: framebuffer formats, unpacker states and the
// per-format geometry helpers used by the unpacker and cursor overlay.
package vga_pkg;

    localparam int unsigned VGA_WORD_W = 128;

    typedef enum logic [1:0] {
        FMT_1BPP     = 2'd0,
        FMT_RGB332   = 2'd1,
        FMT_RGB565   = 2'd2,
        FMT_XRGB8888 = 2'd3
    } fmt_t;

    typedef enum logic {
        UNPACK_IDLE   = 1'b0,
        UNPACK_ACTIVE = 1'b1
    } unpack_cs_t;

    // Bits occupied by one pixel in the packed framebuffer word.
    function automatic int unsigned bpp(fmt_t f);
        case (f)
            FMT_1BPP:   return 1;
            FMT_RGB332: return 8;
            FMT_RGB565: return 16;
            default:    return 32;
        endcase
    endfunction

    // Pixels carried by one FIFO word of width word_w.
    function automatic int unsigned ppw(fmt_t f, int unsigned word_w = VGA_WORD_W);
        return word_w / bpp(f);
    endfunction

endpackage

// File: rtl/vga_pixel_unpack_if.sv
// FWFT read side of the VGA pixel FIFO. The unpacker is the master
// (it issues pops); the FIFO is the slave (it presents the head word).
interface vga_pixel_unpack_if #(
    parameter int unsigned WORD_W = 128
);
    logic [WORD_W-1:0] fifo_data;
    logic              fifo_empty;
    logic              fifo_pop;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_pop
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_pop
    );
endinterface

// File: rtl/vga_color_expand.sv
// Combinational expansion of one packed pixel to 8-8-8 RGB by bit
// replication. Only the low bpp bits of the slice are looked at.
module vga_color_expand
    import vga_pkg::*;
(
    input  fmt_t        i_fmt,
    input  logic [31:0] i_pix,
    output logic [23:0] o_rgb
);

    // Bits [31:24] are padding in xRGB8888 and unused by narrower formats.
    logic w_unused;
    assign w_unused = ^i_pix[31:24];

    // Replicate the top bits of each narrow channel into the low bits.
    always_comb begin
        o_rgb = '0;
        case (i_fmt)
            FMT_1BPP:     o_rgb = {24{i_pix[0]}};
            FMT_RGB332:   o_rgb = {i_pix[7:5], i_pix[7:5], i_pix[7:6],
                                   i_pix[4:2], i_pix[4:2], i_pix[4:3],
                                   {4{i_pix[1:0]}}};
            FMT_RGB565:   o_rgb = {i_pix[15:11], i_pix[15:13],
                                   i_pix[10:5],  i_pix[10:9],
                                   i_pix[4:0],   i_pix[4:2]};
            FMT_XRGB8888: o_rgb = i_pix[23:0];
            default:      o_rgb = '0;
        endcase
    end

endmodule

// File: rtl/vga_pixel_unpack.sv
// Pixel unpacker: walks the FWFT head word LSB-first, emitting one
// expanded RGB pixel per requested cycle, popping the word after its
// last pixel and discarding partial words at each line start.
module vga_pixel_unpack
    import vga_pkg::*;
#(
    parameter int unsigned WORD_W = VGA_WORD_W
) (
    input  logic                vga_clk,
    input  logic                vga_reset,
    input  logic [1:0]          fmt,
    input  logic                line_start,
    input  logic                pix_req,
    vga_pixel_unpack_if.master  fifo,
    output logic [23:0]         pix_rgb,
    output logic                pix_valid,
    input  logic                underflow_clr,
    output logic [15:0]         underflow_cnt
);

    localparam int unsigned IDX_W = $clog2(WORD_W);

    unpack_cs_t        r_state, w_state_n;
    fmt_t              r_fmt_q, w_fmt_n;
    logic [IDX_W-1:0]  r_idx, w_idx_n;
    logic [23:0]       r_pix_rgb, w_rgb_n;
    logic              r_pix_valid;
    logic [15:0]       r_ufl_cnt;

    logic [IDX_W-1:0]  w_idx_last;
    logic [IDX_W-1:0]  w_bitpos;
    logic [WORD_W-1:0] w_shifted;
    logic [31:0]       w_slice;
    logic [23:0]       w_exp_rgb;
    logic              w_pop;
    logic              w_cnt_inc;
    logic              w_unused_hi;

    assign w_idx_last = IDX_W'(ppw(r_fmt_q, WORD_W) - 1);

    // Bit offset of the current pixel: idx * bpp, done as a shift since
    // bpp is a power of two and the product always fits inside the word.
    always_comb begin
        w_bitpos = '0;
        case (r_fmt_q)
            FMT_1BPP:     w_bitpos = r_idx;
            FMT_RGB332:   w_bitpos = {r_idx[IDX_W-4:0], 3'b0};
            FMT_RGB565:   w_bitpos = {r_idx[IDX_W-5:0], 4'b0};
            FMT_XRGB8888: w_bitpos = {r_idx[IDX_W-6:0], 5'b0};
            default:      w_bitpos = '0;
        endcase
    end

    assign w_shifted   = fifo.fifo_data >> w_bitpos;
    assign w_slice     = w_shifted[31:0];
    assign w_unused_hi = ^w_shifted[WORD_W-1:32];

    vga_color_expand u_expand (
        .i_fmt (r_fmt_q),
        .i_pix (w_slice),
        .o_rgb (w_exp_rgb)
    );

    // Next state, pixel selection and pop. line_start has priority over a
    // coincident pix_req: that pixel is black and neither pops nor counts.
    always_comb begin
        w_state_n = r_state;
        w_fmt_n   = r_fmt_q;
        w_idx_n   = r_idx;
        w_rgb_n   = '0;
        w_pop     = 1'b0;
        w_cnt_inc = 1'b0;
        if (line_start) begin
            if (r_state == UNPACK_ACTIVE && r_idx != '0 && !fifo.fifo_empty)
                w_pop = 1'b1;
            w_state_n = UNPACK_ACTIVE;
            w_fmt_n   = fmt_t'(fmt);
            w_idx_n   = '0;
        end else if (r_state == UNPACK_ACTIVE && pix_req) begin
            if (fifo.fifo_empty) begin
                w_cnt_inc = 1'b1;
            end else begin
                w_rgb_n = w_exp_rgb;
                if (r_idx == w_idx_last) begin
                    w_pop   = 1'b1;
                    w_idx_n = '0;
                end else begin
                    w_idx_n = r_idx + 1'b1;
                end
            end
        end
    end

    assign fifo.fifo_pop = w_pop;

    // Control state: FSM, latched format and pixel index.
    always_ff @(posedge vga_clk or posedge vga_reset) begin
        if (vga_reset) begin
            r_state <= UNPACK_IDLE;
            r_fmt_q <= FMT_1BPP;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_n;
            r_fmt_q <= w_fmt_n;
            r_idx   <= w_idx_n;
        end
    end

    // Registered pixel output; valid is simply pix_req one cycle late.
    always_ff @(posedge vga_clk or posedge vga_reset) begin
        if (vga_reset) begin
            r_pix_rgb   <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_rgb   <= w_rgb_n;
            r_pix_valid <= pix_req;
        end
    end

    // Saturating underflow counter; a clear beats a same-cycle increment.
    always_ff @(posedge vga_clk or posedge vga_reset) begin
        if (vga_reset)
            r_ufl_cnt <= '0;
        else if (underflow_clr)
            r_ufl_cnt <= '0;
        else if (w_cnt_inc && r_ufl_cnt != 16'hFFFF)
            r_ufl_cnt <= r_ufl_cnt + 16'd1;
    end

    assign pix_rgb       = r_pix_rgb;
    assign pix_valid     = r_pix_valid;
    assign underflow_cnt = r_ufl_cnt;

endmodule

// File: tb/tb_vga_pixel_unpack.sv
// Directed bench for vga_pixel_unpack with a small FWFT FIFO model.
module tb_vga_pixel_unpack;

    logic        vga_clk;
    logic        vga_reset;
    logic [1:0]  fmt;
    logic        line_start;
    logic        pix_req;
    logic [23:0] pix_rgb;
    logic        pix_valid;
    logic        underflow_clr;
    logic [15:0] underflow_cnt;

    vga_pixel_unpack_if #(.WORD_W(128)) fifo_if ();

    vga_pixel_unpack #(.WORD_W(128)) dut (
        .vga_clk       (vga_clk),
        .vga_reset     (vga_reset),
        .fmt           (fmt),
        .line_start    (line_start),
        .pix_req       (pix_req),
        .fifo          (fifo_if.master),
        .pix_rgb       (pix_rgb),
        .pix_valid     (pix_valid),
        .underflow_clr (underflow_clr),
        .underflow_cnt (underflow_cnt)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    logic [127:0] q[$];
    logic         force_empty;
    int           n_pass;
    int           n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic refresh();
        fifo_if.fifo_empty = force_empty || (q.size() == 0);
        fifo_if.fifo_data  = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic push(input logic [127:0] w);
        q.push_back(w);
        refresh();
    endtask

    // One clock: drive inputs, sample the combinational pop before the
    // edge, let the model pop on the edge, return 1 time unit after it.
    task automatic cyc(input logic req, input logic ls, input logic clr, output logic popped);
        pix_req       = req;
        line_start    = ls;
        underflow_clr = clr;
        #1;
        popped = fifo_if.fifo_pop;
        @(posedge vga_clk);
        #1;
        if (popped && q.size() != 0) void'(q.pop_front());
        refresh();
        pix_req       = 1'b0;
        line_start    = 1'b0;
        underflow_clr = 1'b0;
    endtask

    initial begin
        logic        p;
        int          npops;
        int          last_pop;
        logic [23:0] exp8 [0:7];
        logic [23:0] exp4 [0:3];
        logic [23:0] exp5 [0:4];

        n_pass = 0; n_total = 0;
        force_empty = 1'b0;
        vga_reset = 1'b1; fmt = 2'd0; line_start = 1'b0; pix_req = 1'b0;
        underflow_clr = 1'b0;
        refresh();

        // ---- reset state
        @(posedge vga_clk); @(posedge vga_clk); #1;
        chk("rst_rgb",   32'(pix_rgb), 32'h0);
        chk("rst_valid", 32'(pix_valid), 32'h0);
        chk("rst_cnt",   32'(underflow_cnt), 32'h0);
        chk("rst_pop",   32'(fifo_if.fifo_pop), 32'h0);
        vga_reset = 1'b0;

        // ---- 1bpp alternating
        push({32{4'hA}});
        fmt = 2'd0;
        cyc(1'b0, 1'b1, 1'b0, p);
        chk("mono_ls_pop", 32'(p), 32'h0);
        npops = 0; last_pop = -1;
        for (int i = 0; i < 128; i++) begin
            cyc(1'b1, 1'b0, 1'b0, p);
            if (p) begin npops++; last_pop = i; end
            chk($sformatf("mono_px%0d", i), 32'(pix_rgb), (i % 2 == 1) ? 32'hFFFFFF : 32'h0);
        end
        chk("mono_valid",   32'(pix_valid), 32'h1);
        chk("mono_npops",   32'(npops), 32'd1);
        chk("mono_pop_idx", 32'(last_pop), 32'd127);

        // ---- RGB565 expansion
        push({80'h0, 16'h001F, 16'h07E0, 16'hF800});
        fmt = 2'd2;
        cyc(1'b0, 1'b1, 1'b0, p);
        chk("565_ls_pop", 32'(p), 32'h0);
        exp8 = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, p);
            chk($sformatf("565_px%0d", i), 32'(pix_rgb), 32'(exp8[i]));
            chk($sformatf("565_pop%0d", i), 32'(p), (i == 7) ? 32'h1 : 32'h0);
        end

        // ---- xRGB8888
        push({32'h12345678, 32'hAABBCCDD, 32'h00000000, 32'hFF102030});
        fmt = 2'd3;
        cyc(1'b0, 1'b1, 1'b0, p);
        exp4 = '{24'h102030, 24'h000000, 24'hBBCCDD, 24'h345678};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, p);
            chk($sformatf("8888_px%0d", i), 32'(pix_rgb), 32'(exp4[i]));
            chk($sformatf("8888_pop%0d", i), 32'(p), (i == 3) ? 32'h1 : 32'h0);
        end

        // ---- underflow: FIFO is empty now
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, p);
            chk($sformatf("ufl_px%0d", i), 32'(pix_rgb), 32'h0);
            chk($sformatf("ufl_pop%0d", i), 32'(p), 32'h0);
        end
        chk("ufl_cnt10", 32'(underflow_cnt), 32'd10);
        push({96'h0, 32'h00ABCDEF});
        cyc(1'b1, 1'b0, 1'b0, p);
        chk("ufl_resume_px", 32'(pix_rgb), 32'hABCDEF);
        chk("ufl_cnt_hold",  32'(underflow_cnt), 32'd10);
        cyc(1'b0, 1'b0, 1'b1, p);
        chk("ufl_clr", 32'(underflow_cnt), 32'd0);
        force_empty = 1'b1; refresh();
        cyc(1'b1, 1'b0, 1'b0, p);
        chk("ufl_cnt1", 32'(underflow_cnt), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, p);
        chk("ufl_clr_wins", 32'(underflow_cnt), 32'd0);
        force_empty = 1'b0; refresh();

        // ---- partial flush, RGB332 (idx is 1 on the xRGB word)
        fmt = 2'd1;
        cyc(1'b0, 1'b1, 1'b0, p);
        chk("332_flush0_pop", 32'(p), 32'h1);
        push({88'h0, 8'h00, 8'h92, 8'h03, 8'h1C, 8'hE0});
        push({120'h0, 8'h49});
        exp5 = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h9292AA, 24'h000000};
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, p);
            chk($sformatf("332_px%0d", i), 32'(pix_rgb), 32'(exp5[i]));
            chk($sformatf("332_pop%0d", i), 32'(p), 32'h0);
        end
        cyc(1'b0, 1'b1, 1'b0, p);
        chk("332_flush_pop", 32'(p), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, p);
        chk("332_next_line_px", 32'(pix_rgb), 32'h494955);
        chk("332_next_line_pop", 32'(p), 32'h0);

        // line_start and pix_req together: flush pop only, black, no count
        cyc(1'b1, 1'b1, 1'b0, p);
        chk("ls_req_pop",   32'(p), 32'h1);
        chk("ls_req_rgb",   32'(pix_rgb), 32'h0);
        chk("ls_req_valid", 32'(pix_valid), 32'h1);
        chk("ls_req_cnt",   32'(underflow_cnt), 32'h0);
        push({112'h0, 8'h1C, 8'hFF});
        cyc(1'b1, 1'b0, 1'b0, p);
        chk("ls_req_px0", 32'(pix_rgb), 32'hFFFFFF);
        fmt = 2'd0;   // mid-line change must not take effect
        cyc(1'b1, 1'b0, 1'b0, p);
        chk("fmt_hold_px1", 32'(pix_rgb), 32'h00FF00);

        // ---- reset mid-line, xRGB8888
        fmt = 2'd3;
        cyc(1'b0, 1'b1, 1'b0, p);
        chk("rml_flush_pop", 32'(p), 32'h1);
        push({32'h4, 32'h3, 32'h2, 32'h1});
        push({32'h8, 32'h7, 32'h6, 32'h5});
        npops = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b0, 1'b0, p);
            if (p) npops++;
            chk($sformatf("rml_px%0d", i), 32'(pix_rgb), 32'(i + 1));
        end
        chk("rml_npops", 32'(npops), 32'd1);
        force_empty = 1'b1; refresh();
        cyc(1'b1, 1'b0, 1'b0, p);
        cyc(1'b1, 1'b0, 1'b0, p);
        chk("rml_cnt2", 32'(underflow_cnt), 32'd2);
        force_empty = 1'b0; refresh();
        pix_req = 1'b1;
        vga_reset = 1'b1;
        #1;
        chk("rml_rgb",   32'(pix_rgb), 32'h0);
        chk("rml_valid", 32'(pix_valid), 32'h0);
        chk("rml_cnt",   32'(underflow_cnt), 32'h0);
        chk("rml_pop",   32'(fifo_if.fifo_pop), 32'h0);
        @(posedge vga_clk); #1;
        vga_reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, p);
        chk("post_rst_pop",   32'(p), 32'h0);
        chk("post_rst_rgb",   32'(pix_rgb), 32'h0);
        chk("post_rst_valid", 32'(pix_valid), 32'h1);
        chk("post_rst_cnt",   32'(underflow_cnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
